// File: rtl/axi_burst_rd_master.sv
// AXI4 read master: splits a (start address, burst count) job into fixed 16-beat
// INCR bursts with bounded outstanding ARs and streams the returned beats on AXIS.
module axi_burst_rd_master #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  RSTART_REG,
  input  logic [31:0]           RADDR_REG,
  input  logic [31:0]           RNBURST_REG,
  output logic                  RDONE_REG,
  output logic                  RERR_REG,
  output logic [1:0]            dbg_state,
  output logic                  m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);
  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // a source never drops valid or changes payload while valid && !ready.
  localparam int              BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
  localparam int              OFFS        = $clog2(BURST_BYTES);
  localparam logic [3:0]      LAST_BEAT   = 4'(BURST_LEN - 1);
  localparam logic [24:0]     MAX_OS      = 25'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DRAIN = 2'd2, END = 2'd3} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [24:0]           nburst_q, ar_cnt, done_cnt, done_nxt, ar_cnt_inc;
  logic [3:0]            beat_cnt;
  logic                  arvalid_q, err_q;
  logic                  out_valid, out_last, skid_valid, skid_last;
  logic [DATA_WIDTH-1:0] out_data, skid_data;
  logic                  accepting, r_hs, ar_hs, out_free, beat_tlast;
  logic                  unused_ok;

  assign unused_ok  = ^{m_axi_rid, RNBURST_REG[31:25]};
  assign accepting  = (state == ADDR) || (state == DRAIN);
  assign m_axi_rready = accepting && !skid_valid;
  assign r_hs       = m_axi_rvalid && m_axi_rready;
  assign ar_hs      = arvalid_q && m_axi_arready;
  assign out_free   = !out_valid || m_axis_tready;
  assign done_nxt   = done_cnt + {24'd0, r_hs && m_axi_rlast};
  assign ar_cnt_inc = ar_cnt + 25'd1;
  assign beat_tlast = (done_cnt == nburst_q - 25'd1) && m_axi_rlast;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (RSTART_REG) state_nxt = (RNBURST_REG[24:0] != 25'd0) ? ADDR : END;
      ADDR:    if (ar_hs && (ar_cnt_inc == nburst_q)) state_nxt = DRAIN;
      // Leave as the last beat is being taken so RDONE follows it by one cycle.
      DRAIN:   if ((done_cnt == nburst_q) && !skid_valid && out_free) state_nxt = END;
      END:     if (!RSTART_REG) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q    <= '0;
      nburst_q  <= '0;
      ar_cnt    <= '0;
      done_cnt  <= '0;
      beat_cnt  <= '0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if ((state == IDLE) && RSTART_REG) begin
        addr_q   <= {RADDR_REG[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
        err_q    <= |RADDR_REG[OFFS-1:0];
        nburst_q <= RNBURST_REG[24:0];
        ar_cnt   <= '0;
        done_cnt <= '0;
        beat_cnt <= '0;
      end
      // Outstanding is judged on next-cycle counts, so an AR and an RLAST in the
      // same cycle leave arvalid asserted.
      if (state == ADDR) begin
        if (ar_hs) begin
          addr_q    <= addr_q + ADDR_WIDTH'(BURST_BYTES);
          ar_cnt    <= ar_cnt_inc;
          arvalid_q <= (ar_cnt_inc != nburst_q) && ((ar_cnt_inc - done_nxt) < MAX_OS);
        end else if (!arvalid_q) begin
          arvalid_q <= (ar_cnt - done_nxt) < MAX_OS;
        end
      end else begin
        arvalid_q <= 1'b0;
      end
      if (r_hs) begin
        done_cnt <= done_nxt;
        beat_cnt <= m_axi_rlast ? 4'd0 : beat_cnt + 4'd1;
        if ((m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_cnt == LAST_BEAT))) err_q <= 1'b1;
      end
    end
  end

  // Two-entry skid: rready only depends on the skid flop, so one beat can land
  // in the skid while the output register is stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= 1'b0;
      end else if (r_hs) begin
        out_valid <= 1'b1;
        out_data  <= m_axi_rdata;
        out_last  <= beat_tlast;
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end else if (r_hs) begin
      skid_valid <= 1'b1;
      skid_data  <= m_axi_rdata;
      skid_last  <= beat_tlast;
    end
  end

  assign RDONE_REG     = (state == END);
  assign RERR_REG      = err_q;
  assign dbg_state     = state;
  assign m_axi_arid    = 1'b0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'd3;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;
endmodule

// File: tb/tb_axi_burst_rd_master.sv
// Bench for axi_burst_rd_master: AXI slave model with AR/R scoreboards and an
// AXIS sink that checks every beat, tlast, stall stability and job completion.
module tb_axi_burst_rd_master;
  localparam int W = 65;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        RSTART_REG = 1'b0;
  logic [31:0] RADDR_REG = '0;
  logic [31:0] RNBURST_REG = '0;
  logic        RDONE_REG, RERR_REG;
  logic [1:0]  dbg_state;
  logic        arid, arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, rresp = 2'b00;
  logic [3:0]  arcache;
  logic        rid = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready;
  logic [63:0] rdata = '0;
  logic        tvalid, tlast, tready = 1'b0;
  logic [63:0] tdata;

  axi_burst_rd_master dut (
    .clk(clk), .rstn(rstn),
    .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG), .RNBURST_REG(RNBURST_REG),
    .RDONE_REG(RDONE_REG), .RERR_REG(RERR_REG), .dbg_state(dbg_state),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tlast(tlast),
    .m_axis_tready(tready)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int            n_checks = 0, n_fail = 0;
  logic [31:0]   exp_ar_q[$];
  logic [W-1:0]  exp_q[$];
  int            ar_acc, bursts_ret, beat_in_burst, job_beat, t_beats, jc;
  int            job_nburst, ar_mode, t_mode, r_hold, err_beat;
  logic          r_pending, t_stalled, ar_stalled, done_due;
  logic [63:0]   t_saved;
  logic [31:0]   ar_saved;
  logic [31:0]   data_ctr = 32'h0000_1000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_ar_q.delete();
    exp_q.delete();
    ar_acc = 0; bursts_ret = 0; beat_in_burst = 0; job_beat = 0; t_beats = 0; jc = 0;
    r_pending = 1'b0; t_stalled = 1'b0; ar_stalled = 1'b0; done_due = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  // One cycle: check held state, drive inputs at the negedge, then account for
  // the transfers the next posedge will perform.
  task automatic step();
    logic [W-1:0] e;
    @(negedge clk);
    jc++;
    if (t_stalled) check("tdata_hold", {63'd0, tvalid} << 0 | (tdata ^ t_saved) << 1, 64'd1);
    if (ar_stalled) check("araddr_hold", {31'd0, arvalid, araddr}, {31'd0, 1'b1, ar_saved});
    if (done_due) check("rdone_rise", 64'(RDONE_REG), 64'd1);
    done_due = 1'b0;
    case (ar_mode)
      0:       arready = 1'b1;
      1:       arready = (jc % 4 == 0);
      default: arready = 1'($urandom_range(0, 1));
    endcase
    tready = (t_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (!r_pending) begin
      if (jc > r_hold && ar_acc > bursts_ret) begin
        rvalid = 1'b1;
        rdata  = {~data_ctr, data_ctr};
        rlast  = (beat_in_burst == 15);
        rresp  = (job_beat == err_beat) ? 2'b10 : 2'b00;
        r_pending = 1'b1;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
    end
    t_stalled  = tvalid && !tready;
    t_saved    = tdata;
    ar_stalled = arvalid && !arready;
    ar_saved   = araddr;
    if (arvalid && arready) begin
      check("ar_outstanding", 64'((ar_acc - bursts_ret) < 8), 64'd1);
      if (exp_ar_q.size() == 0) check("ar_extra", 64'd1, 64'd0);
      else check("araddr", 64'(araddr), 64'(exp_ar_q.pop_front()));
      ar_acc++;
    end
    if (rvalid && rready) begin
      exp_q.push_back({rlast && (bursts_ret == job_nburst - 1), rdata});
      r_pending = 1'b0;
      data_ctr++;
      job_beat++;
      if (rlast) begin bursts_ret++; beat_in_burst = 0; end
      else beat_in_burst++;
    end
    if (tvalid && tready) begin
      t_beats++;
      if (exp_q.size() == 0) check("t_extra", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("tdata", tdata, e[63:0]);
        check("tlast", 64'(tlast), 64'(e[64]));
        if (e[64]) begin
          check("rdone_early", 64'(RDONE_REG), 64'd0);
          done_due = 1'b1;
        end
      end
    end
  endtask

  task automatic run_job(input logic [31:0] addr, input int nb, input int arm, input int tm,
                         input int rh, input int eb, input int abort_burst);
    logic [31:0] base;
    int cycles;
    logic aborted, exp_err;
    clear_model();
    job_nburst = nb; ar_mode = arm; t_mode = tm; r_hold = rh; err_beat = eb;
    base = addr & 32'hFFFF_FF80;
    for (int i = 0; i < nb; i++) exp_ar_q.push_back(base + 32'(128 * i));
    exp_err = (addr[6:0] != 7'd0) || (eb >= 0);
    @(negedge clk);
    RSTART_REG = 1'b1; RADDR_REG = addr; RNBURST_REG = 32'(nb);
    cycles = 0; aborted = 1'b0;
    while (1) begin
      step();
      cycles++;
      if (rh > 0 && jc == rh) begin
        check("ar_cap_count", 64'(ar_acc), 64'd8);
        check("ar_cap_arvalid", 64'(arvalid), 64'd0);
      end
      if (abort_burst > 0 && bursts_ret == abort_burst && beat_in_burst == 5) begin
        rstn = 1'b0; RSTART_REG = 1'b0; arready = 1'b0; rvalid = 1'b0; tready = 1'b0;
        @(negedge clk);
        check("rst_ar", {31'd0, arvalid, araddr}, 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_flags", 64'({rready, tvalid, tlast, RDONE_REG, RERR_REG, dbg_state}), 64'd0);
        rstn = 1'b1;
        clear_model();
        aborted = 1'b1;
        break;
      end
      if (RDONE_REG) break;
      if (cycles > 5000) begin
        check("timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (!aborted) begin
      check("rdone", 64'(RDONE_REG), 64'd1);
      check("beats", 64'(t_beats), 64'(16 * nb));
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      check("ar_all", 64'(ar_acc), 64'(nb));
      check("rerr", 64'(RERR_REG), 64'(exp_err));
      if (nb == 0) check("zero_latency", 64'(cycles), 64'd1);
      @(negedge clk);
      RSTART_REG = 1'b0;
      check("end_hold", 64'(RDONE_REG), 64'd1);
      @(negedge clk);
      check("idle_after", 64'({dbg_state, RDONE_REG}), 64'd0);
    end
    clear_model();
  endtask

  initial begin
    clear_model();
    ar_mode = 0; t_mode = 0; r_hold = 0; err_beat = -1; job_nburst = 0;
    repeat (3) @(negedge clk);
    check("reset_ar", {31'd0, arvalid, araddr}, 64'd0);
    check("reset_t", tdata, 64'd0);
    check("reset_flags", 64'({rready, tvalid, tlast, RDONE_REG, RERR_REG, dbg_state}), 64'd0);
    check("ar_const", 64'({arid, arlen, arsize, arburst, arcache, arprot}),
          64'({1'b0, 8'd15, 3'd3, 2'b01, 4'b0011, 3'b000}));
    rstn = 1'b1;
    @(negedge clk);

    run_job(32'h1000_0000, 1,  0, 0, 0,   -1, 0);  // single burst
    run_job(32'h2000_0000, 4,  1, 0, 0,   -1, 0);  // AR backpressure
    run_job(32'h3000_0000, 20, 0, 0, 100, -1, 0);  // outstanding cap
    run_job(32'h4000_0000, 8,  2, 1, 0,   -1, 0);  // downstream stall
    run_job(32'h0000_0000, 0,  0, 0, 0,   -1, 0);  // zero bursts
    run_job(32'h0000_0044, 1,  0, 0, 0,   -1, 0);  // misaligned address
    run_job(32'h5000_0000, 2,  0, 1, 0,    4, 0);  // rresp error on beat 5
    run_job(32'h6000_0000, 6,  2, 1, 0,   -1, 2);  // reset during burst 3
    run_job(32'hFFFF_FF80, 2,  0, 0, 0,   -1, 0);  // address wrap, after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_burst_rd_master.md
# axi_burst_rd_master

AXI4 read master sitting between the DDR interconnect and the weight/feature-map loader. Accepts a job (start address + burst count) on the RSTART/RADDR/RNBURST register-style handshake, issues fixed 16-beat INCR bursts with bounded outstanding requests, and streams returned 64-bit beats on an AXIS master port to the loader's FIFO reader. Signals job completion with RDONE_REG once every beat has been accepted downstream.

## Interface
Reset is rstn, synchronous, active-low; the clock is clk.

Parameters:
- DATA_WIDTH, 64: AXI/AXIS data width. Only 64 is supported.
- ADDR_WIDTH, 32: AXI address width.
- BURST_LEN, 16: beats per burst (ARLEN = 15). Together with DATA_WIDTH this gives 128 bytes per burst.
- MAX_OUTSTANDING, 8: maximum number of issued AR bursts not yet completed by RLAST. Must be a power of 2, ≤ 16.

Ports:
- clk in 1: clock.
- rstn in 1: synchronous active-low reset.
- RSTART_REG in 1: level start; held high by the loader for the whole job.
- RADDR_REG in 32: job byte address. Bits [6:0] must be 0.
- RNBURST_REG in 32: number of 128-byte bursts; only bits [24:0] are used.
- RDONE_REG out 1: high in END state.
- RERR_REG out 1: sticky error flag, cleared on job start.
- m_axi_arid out 1: constant 0.
- m_axi_araddr out ADDR_WIDTH: burst address.
- m_axi_arlen out 8: constant 15.
- m_axi_arsize out 3: constant 3.
- m_axi_arburst out 2: constant 01.
- m_axi_arcache out 4: constant 0011.
- m_axi_arprot out 3: constant 000.
- m_axi_arvalid out 1, m_axi_arready in 1: AR handshake.
- m_axi_rid in 1: ignored.
- m_axi_rdata in DATA_WIDTH.
- m_axi_rresp in 2.
- m_axi_rlast in 1.
- m_axi_rvalid in 1, m_axi_rready out 1: R handshake.
- m_axis_tvalid out 1, m_axis_tdata out DATA_WIDTH, m_axis_tlast out 1, m_axis_tready in 1: output stream. tlast marks the final beat of the job.

## Operation
- FSM states: IDLE, ADDR, DRAIN, END.
- **IDLE.** When RSTART_REG=1:
  - Latch the address as RADDR_REG with bits [6:0] forced to 0. Set RERR_REG if those bits were nonzero; otherwise clear RERR_REG.
  - Latch nburst = RNBURST_REG[24:0] and clear all counters.
  - Go to ADDR if nburst≠0; go to END if nburst=0.
- **ADDR.** Issues one AR per burst:
  - arvalid is registered and asserts when (ar_cnt − done_cnt) < MAX_OUTSTANDING.
  - araddr/arvalid stay stable until arready.
  - On each handshake: araddr += 128, ar_cnt += 1.
  - When ar_cnt reaches nburst (on the handshake), go to DRAIN.
- **DRAIN.** Go to END when done_cnt = nburst and the output buffer is empty.
- **END.** RDONE_REG=1. Go to IDLE on the first cycle with RSTART_REG=0; RSTART_REG staying high holds END.
- **R path.**
  - Accept R beats in ADDR/DRAIN only.
  - beat_cnt (4 bits) counts beats within the current burst.
  - A beat with rlast=1 increments done_cnt and resets beat_cnt.
  - Set RERR_REG if rresp≠00, or if rlast disagrees with beat_cnt==15. Data is still forwarded; the job is not aborted.
- **Output buffer.** 2-entry skid: an output register plus a skid register.
  - rready = ~skid_valid (registered).
  - tdata/tvalid/tlast change only when tvalid=0 or tready=1.
  - tlast = (done_cnt == nburst−1) && rlast for the captured beat.
- **Counters.** ar_cnt and done_cnt are 25 bits. The address adder wraps modulo 2^32.
- **Reset mid-job.** Return to IDLE, clear all outputs, drop any buffered data. The interconnect must be reset concurrently.
- **RSTART_REG low mid-job.** Ignored; the job runs to END, and END then exits next cycle.

## Timing
- Reset values:
  - arvalid=0, araddr=0, rready=0, tvalid=0, tlast=0, tdata=0.
  - RDONE_REG=0, RERR_REG=0, state=IDLE.
- IDLE→ADDR takes 1 cycle after RSTART_REG is sampled high. First arvalid is 1 cycle after entering ADDR.
- Back-to-back ARs: with arready=1, one AR per cycle.
- Data latency: R handshake at cycle t → tvalid at t+1.
- Full throughput: 1 beat/cycle when rvalid=tready=1.
- RDONE_REG rises 1 cycle after the final beat handshake on AXIS.
- Simultaneous AR handshake and RLAST in one cycle: outstanding stays unchanged, so an arvalid held high stays high.

## Test plan
- **Single burst.** RADDR=0x1000_0000, RNBURST=1, arready=rvalid=tready=1 → one AR (addr 0x1000_0000, len 15), 16 AXIS beats with tlast on beat 16, RDONE 1 cycle later. After RSTART drops, IDLE.
- **AR backpressure.** RNBURST=4, arready low 3 cycles of every 4 → AR addrs 0x..000/080/100/180 in order, araddr stable while stalled, 64 beats out.
- **Outstanding cap.** RNBURST=20, rvalid withheld for 100 cycles → exactly 8 ARs issued, then arvalid=0 until RLAST beats return. All 320 beats delivered.
- **Downstream stall.** tready toggles 1/0 randomly over 8 bursts → no beat lost or duplicated (incrementing data pattern checked), tdata stable during stalls.
- **Zero bursts and alignment.** RNBURST=0 → END in 1 cycle, no AR. RADDR=0x44 → RERR_REG=1, AR address 0x00.
- **Error and reset.** rresp=10 on beat 5 → RERR_REG=1, job completes. rstn low during burst 3 of 6 → all outputs at reset values next cycle, IDLE.
